dict_builder: RTL and testbench
===============================

Name: dict_builder

Overview:
- Synthesisable successor to the bench-only dictionary loader.
- Builds Forth dictionary entries in byte-wide memory from a start request plus a streamed name.
- Entry layout: link field (ctx), name length, name bytes, parameter field (opcode).
- Generalised in link width, opcode width, name limit and memory bound; adds handshaking, length/overflow checking and abort with no ctx/here corruption. Sits between the outer interpreter and the 8-bit memory bus master.

Parameters:
ASZ, 17, address width
DICT, 'h100, dictionary base; here reset value
LNK, 2, link field bytes (1..3), little-endian
OPB, 1, parameter field bytes (1..4), little-endian
NMAX, 31, maximum legal name length (1..255)
DEND, 'h1FFFF, last writable dictionary address

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a new entry; sampled only in IDLE
len  in  8  name length, captured with start
op  in  8*OPB  parameter field value, captured with start
abort  in  1  cancel entry in progress
nm_valid  in  1  name byte valid
nm_data  in  8  name byte
nm_ready  out  1  name byte accepted when nm_valid & nm_ready
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
err  out  2  status, valid with done: 0 ok, 1 bad len, 2 overflow, 3 aborted
we  out  1  memory write enable
ai  out  ASZ  memory address
vi  out  8  memory write data
ctx  out  ASZ  address of latest entry (link head)
here  out  ASZ  next free dictionary address

Behaviour:
- Reset values: ctx={ASZ{1'b1}} (null link), here=DICT, we=0, ai=0, vi=0, nm_ready=0, busy=0, done=0, err=0, state IDLE. Reset mid-entry discards the entry; writes already issued are not undone.
- States: IDLE, CHK, LINK, LEN, NAME, PARM, FIN.
- IDLE, start=1: capture len, op, base=here; go to CHK.
- CHK, one cycle, no write:
  - len==0 or len>NMAX -> FIN, err=1.
  - base+LNK+1+len+OPB-1 > DEND, computed at ASZ+2 bits -> FIN, err=2.
  - Otherwise -> LINK.
- LINK: LNK cycles, we=1, ai=base+i, vi=ctx[8i+7:8i]. ctx is zero-extended if LNK*8>ASZ.
- LEN: one cycle, ai=base+LNK, vi=len.
- NAME: nm_ready=1.
  - Each accepted byte written the same cycle at base+LNK+1+k, k=0..len-1.
  - we=0 on cycles with nm_valid=0.
  - After byte len-1 -> PARM.
- PARM: OPB cycles, ai=pfa+j, vi=op[8j+7:8j], where pfa=base+LNK+1+len.
- FIN: done=1 for one cycle, then IDLE.
  - On err=0 in the same cycle: ctx<=base, here<=pfa+OPB.
  - On any error, ctx/here are unchanged.
- Abort, sampled in CHK..PARM: next state FIN with err=3, we=0 that cycle, ctx/here unchanged. Abort in IDLE or FIN is ignored. Abort wins over a simultaneous name handshake; that byte is not written.
- start while busy is ignored. start in the FIN cycle is ignored; it must be re-asserted in IDLE.
- Latency with continuous nm_valid: start cycle, plus CHK, plus LNK+1+len+OPB write cycles, plus FIN. Defaults with len=3: done 9 cycles after start is sampled.
- The memory slave samples on the opposite edge; the block holds ai/vi/we stable for the whole cycle.

Test Plan:
- Reset, then "dup" op=01 with defaults: writes 100:ff,101:ff,102:03,103:'d',104:'u',105:'p',106:01; done with err=0; ctx=100, here=107.
- Follow with "+" op=04: writes 107:00,108:01,109:01,10A:'+',10B:04; ctx=107, here=10C. Read back both entries through the memory.
- nm_valid toggled every other cycle during "swap": no write on idle cycles, byte order preserved, final image identical to continuous-stream run.
- len=0 and len=32 (NMAX=31): done with err=1 two cycles after start, no we pulse, ctx/here unchanged.
- DEND=here+5, len=4: err=2 with no writes. Abort asserted on the 2nd name byte of "drop": done with err=3, ctx/here keep prior values, next entry overwrites from the same base.
- LNK=3, OPB=2, op=16'hBEEF, name "x": link 3 bytes, then 01,'x',EF,BE; here advances by 7. rst pulsed mid-NAME: outputs return to reset values immediately.

Source files
------------

// File: rtl/dict_builder.sv
// Forth dictionary entry builder: writes link, name length, name bytes and
// parameter field to a byte-wide memory bus, then commits ctx/here on success.
module dict_builder #(
  parameter int             ASZ  = 17,
  parameter logic [ASZ-1:0] DICT = 'h100,
  parameter int             LNK  = 2,
  parameter int             OPB  = 1,
  parameter int             NMAX = 31,
  parameter logic [ASZ-1:0] DEND = 'h1FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic [8*OPB-1:0] op,
  input  logic             abort,
  input  logic             nm_valid,
  input  logic [7:0]       nm_data,
  output logic             nm_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             we,
  output logic [ASZ-1:0]   ai,
  output logic [7:0]       vi,
  output logic [ASZ-1:0]   ctx,
  output logic [ASZ-1:0]   here
);

  localparam int CW = (LNK * 8 > ASZ) ? LNK * 8 : ASZ;

  typedef enum logic [2:0] {IDLE, CHK, LINK, LEN, NAME, PARM, FIN} state_t;

  state_t           state;
  logic [ASZ-1:0]   base;
  logic [ASZ-1:0]   ai_reg;
  logic [7:0]       vi_reg;
  logic [7:0]       len_r;
  logic [7:0]       cnt;
  logic [8*OPB-1:0] op_r;
  logic [1:0]       err_reg;

  logic [CW-1:0]    ctx_ext;
  logic [ASZ+1:0]   last_addr;
  logic [ASZ-1:0]   here_next;
  logic             len_bad;
  logic             ovf;
  logic             in_entry;
  logic             writing;

  assign ctx_ext   = CW'(ctx);
  // Extra two bits keep the end-of-entry address from wrapping near the top of memory.
  assign last_addr = (ASZ+2)'(base) + (ASZ+2)'(LNK + OPB) + (ASZ+2)'(len_r);
  assign ovf       = last_addr > (ASZ+2)'(DEND);
  assign len_bad   = (len_r == 8'd0) || (int'(len_r) > NMAX);
  assign here_next = base + ASZ'(LNK + 1 + OPB) + ASZ'(len_r);

  assign in_entry  = state inside {CHK, LINK, LEN, NAME, PARM};
  assign writing   = (state inside {LINK, LEN, PARM}) || (state == NAME && nm_valid);

  // Abort suppresses the write of the cycle it is seen in, including a name byte.
  assign we        = writing && !abort;
  assign ai        = ai_reg;
  assign vi        = (state == NAME) ? nm_data : vi_reg;
  assign nm_ready  = (state == NAME);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      ai_reg  <= '0;
      vi_reg  <= '0;
      len_r   <= '0;
      cnt     <= '0;
      op_r    <= '0;
      err_reg <= 2'd0;
      ctx     <= '1;
      here    <= DICT;
    end else if (abort && in_entry) begin
      state   <= FIN;
      err_reg <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base    <= here;
            len_r   <= len;
            op_r    <= op;
            err_reg <= 2'd0;
            cnt     <= '0;
            state   <= CHK;
          end
        end
        CHK: begin
          if (len_bad) begin
            err_reg <= 2'd1;
            state   <= FIN;
          end else if (ovf) begin
            err_reg <= 2'd2;
            state   <= FIN;
          end else begin
            ai_reg <= base;
            vi_reg <= ctx_ext[7:0];
            cnt    <= '0;
            state  <= LINK;
          end
        end
        LINK: begin
          ai_reg <= ai_reg + 1'b1;
          if (cnt == 8'(LNK - 1)) begin
            vi_reg <= len_r;
            cnt    <= '0;
            state  <= LEN;
          end else begin
            vi_reg <= 8'(ctx_ext >> (8 * (int'(cnt) + 1)));
            cnt    <= cnt + 8'd1;
          end
        end
        LEN: begin
          ai_reg <= ai_reg + 1'b1;
          cnt    <= '0;
          state  <= NAME;
        end
        NAME: begin
          if (nm_valid) begin
            ai_reg <= ai_reg + 1'b1;
            if (cnt == len_r - 8'd1) begin
              vi_reg <= op_r[7:0];
              cnt    <= '0;
              state  <= PARM;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        PARM: begin
          if (cnt == 8'(OPB - 1)) begin
            err_reg <= 2'd0;
            state   <= FIN;
          end else begin
            ai_reg <= ai_reg + 1'b1;
            vi_reg <= 8'(op_r >> (8 * (int'(cnt) + 1)));
            cnt    <= cnt + 8'd1;
          end
        end
        FIN: begin
          if (err_reg == 2'd0) begin
            ctx  <= base;
            here <= here_next;
          end
          ai_reg <= '0;
          vi_reg <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_builder.sv
// Directed bench for dict_builder: two instances (default layout and a
// 3-byte link / 2-byte parameter variant) each backed by a small byte memory.
module tb_dict_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        abort = 1'b0, nm_valid = 1'b0;
  logic [7:0]  len = 8'd0, nm_data = 8'd0;
  logic [31:0] opv = 32'd0;

  logic        nm_ready0, busy0, done0, we0;
  logic [1:0]  err0;
  logic [16:0] ai0, ctx0, here0;
  logic [7:0]  vi0;
  logic        nm_ready1, busy1, done1, we1;
  logic [1:0]  err1;
  logic [16:0] ai1, ctx1, here1;
  logic [7:0]  vi1;

  logic [7:0]  mem0 [0:511];
  logic [7:0]  mem1 [0:511];
  int          wc0 = 0, wc1 = 0, gapw = 0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dict_builder u0 (
    .clk(clk), .rst(rst), .start(start0), .len(len), .op(opv[7:0]), .abort(abort),
    .nm_valid(nm_valid), .nm_data(nm_data), .nm_ready(nm_ready0), .busy(busy0),
    .done(done0), .err(err0), .we(we0), .ai(ai0), .vi(vi0), .ctx(ctx0), .here(here0)
  );

  dict_builder #(.LNK(3), .OPB(2), .DEND(17'h10C)) u1 (
    .clk(clk), .rst(rst), .start(start1), .len(len), .op(opv[15:0]), .abort(abort),
    .nm_valid(nm_valid), .nm_data(nm_data), .nm_ready(nm_ready1), .busy(busy1),
    .done(done1), .err(err1), .we(we1), .ai(ai1), .vi(vi1), .ctx(ctx1), .here(here1)
  );

  // Memory slaves sample on the falling edge.
  always @(negedge clk) begin
    if (we0) begin
      mem0[ai0[8:0]] <= vi0;
      wc0 <= wc0 + 1;
      if (nm_ready0 && !nm_valid) gapw <= gapw + 1;
    end
    if (we1) begin
      mem1[ai1[8:0]] <= vi1;
      wc1 <= wc1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_img(input int sel, input string tag, input int a, input logic [7:0] b[$]);
    foreach (b[i])
      check($sformatf("%s[%0h]", tag, a + i), (sel == 0) ? mem0[a + i] : mem1[a + i], b[i]);
  endtask

  // One entry: pulse start, stream the name, optionally abort at byte index abort_at.
  task automatic run_entry(input int sel, input string nm, input int ln, input logic [31:0] o,
                           input bit gap, input int abort_at,
                           output logic [1:0] e, output int lat);
    int  k = 0;
    int  cyc = 0;
    bit  tog = 1'b0;
    bit  acc;
    bit  fin = 1'b0;
    e   = 2'b00;
    lat = -1;
    len = 8'(ln);
    opv = o;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    while (!fin && cyc < 200) begin
      nm_valid = (k < ln) && (k < nm.len()) && (!gap || tog);
      nm_data  = (k < nm.len()) ? nm[k] : 8'h00;
      abort    = (abort_at >= 0) && (k == abort_at) && ((sel == 0) ? nm_ready0 : nm_ready1);
      @(negedge clk);
      cyc++;
      acc = nm_valid && ((sel == 0) ? nm_ready0 : nm_ready1);
      if ((sel == 0) ? done0 : done1) begin
        fin = 1'b1;
        lat = cyc;
        e   = (sel == 0) ? err0 : err1;
      end
      @(posedge clk); #1;
      if (acc && !abort) k++;
      tog = !tog;
    end
    nm_valid = 1'b0;
    abort    = 1'b0;
    check({nm, " done seen"}, 32'(fin), 32'd1);
    $display("entry u%0d \"%s\" len=%0d err=%0d latency=%0d", sel, nm, ln, e, lat);
  endtask

  logic [1:0]  e;
  int          lat, w;
  logic [7:0]  q[$];

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst ctx", ctx0, 32'h1FFFF);
    check("rst here", here0, 32'h100);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst err", err0, 0);
    check("rst we", we0, 0);
    check("rst nm_ready", nm_ready0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    w = wc0;
    run_entry(0, "dup", 3, 32'h01, 1'b0, -1, e, lat);
    check("dup err", e, 0);
    check("dup latency", lat, 9);
    check("dup writes", wc0 - w, 7);
    check("dup ctx", ctx0, 32'h100);
    check("dup here", here0, 32'h107);

    w = wc0;
    run_entry(0, "+", 1, 32'h04, 1'b0, -1, e, lat);
    check("plus err", e, 0);
    check("plus latency", lat, 7);
    check("plus writes", wc0 - w, 5);
    check("plus ctx", ctx0, 32'h107);
    check("plus here", here0, 32'h10C);
    q = '{8'hFF, 8'hFF, 8'h03, 8'h64, 8'h75, 8'h70, 8'h01};
    check_img(0, "dup img", 'h100, q);
    q = '{8'h00, 8'h01, 8'h01, 8'h2B, 8'h04};
    check_img(0, "plus img", 'h107, q);

    w = wc0;
    run_entry(0, "swap", 4, 32'h02, 1'b1, -1, e, lat);
    check("swap err", e, 0);
    check("swap writes", wc0 - w, 8);
    check("swap gap writes", gapw, 0);
    check("swap ctx", ctx0, 32'h10C);
    check("swap here", here0, 32'h114);
    q = '{8'h07, 8'h01, 8'h04, 8'h73, 8'h77, 8'h61, 8'h70, 8'h02};
    check_img(0, "swap img", 'h10C, q);

    w = wc0;
    run_entry(0, "", 0, 32'h09, 1'b0, -1, e, lat);
    check("len0 err", e, 1);
    check("len0 latency", lat, 2);
    w = w - wc0;
    check("len0 writes", w, 0);
    w = wc0;
    run_entry(0, "", 32, 32'h09, 1'b0, -1, e, lat);
    check("len32 err", e, 1);
    check("len32 latency", lat, 2);
    check("len32 writes", wc0 - w, 0);
    check("badlen ctx", ctx0, 32'h10C);
    check("badlen here", here0, 32'h114);

    w = wc0;
    run_entry(0, "drop", 4, 32'h03, 1'b0, 1, e, lat);
    check("drop err", e, 3);
    check("drop writes", wc0 - w, 4);
    check("drop ctx", ctx0, 32'h10C);
    check("drop here", here0, 32'h114);
    run_entry(0, "nip", 3, 32'h05, 1'b0, -1, e, lat);
    check("nip err", e, 0);
    check("nip ctx", ctx0, 32'h114);
    check("nip here", here0, 32'h11B);
    q = '{8'h0C, 8'h01, 8'h03, 8'h6E, 8'h69, 8'h70, 8'h05};
    check_img(0, "nip img", 'h114, q);

    w = wc1;
    run_entry(1, "x", 1, 32'hBEEF, 1'b0, -1, e, lat);
    check("x err", e, 0);
    check("x latency", lat, 9);
    check("x writes", wc1 - w, 7);
    check("x ctx", ctx1, 32'h100);
    check("x here", here1, 32'h107);
    q = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'h78, 8'hEF, 8'hBE};
    check_img(1, "x img", 'h100, q);

    w = wc1;
    run_entry(1, "abcd", 4, 32'h1234, 1'b0, -1, e, lat);
    check("ovf err", e, 2);
    check("ovf latency", lat, 2);
    check("ovf writes", wc1 - w, 0);
    check("ovf ctx", ctx1, 32'h100);
    check("ovf here", here1, 32'h107);

    // Reset while u0 waits in NAME with a byte on the bus.
    len    = 8'd2;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int t = 0; t < 20 && !nm_ready0; t++) begin
      @(posedge clk); #1;
    end
    check("mid name ready", nm_ready0, 1);
    nm_valid = 1'b1;
    nm_data  = 8'h79;
    #1;
    check("mid name we", we0, 1);
    check("mid name ai", ai0, 32'h11E);
    rst = 1'b1;
    #1;
    check("mid rst busy", busy0, 0);
    check("mid rst nm_ready", nm_ready0, 0);
    check("mid rst we", we0, 0);
    check("mid rst ai", ai0, 0);
    check("mid rst vi", vi0, 0);
    check("mid rst ctx", ctx0, 32'h1FFFF);
    check("mid rst here", here0, 32'h100);
    check("mid rst here u1", here1, 32'h100);
    nm_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
